// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel transmitter.
package vga_pkg;

  localparam int RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } tx_state_t;

  // Total period of a line (in pixels) or of a frame (in lines).
  function automatic int timing_total(input int disp, input int fp,
                                      input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

  function automatic int htotal(input int hdisp, input int hfp,
                                input int hpulse, input int hbp);
    return timing_total(hdisp, hfp, hpulse, hbp);
  endfunction

  function automatic int vtotal(input int vdisp, input int vfp,
                                input int vpulse, input int vbp);
    return timing_total(vdisp, vfp, vpulse, vbp);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel stream handshake plus the VGA/DAC bundle and status pulses.
// master: the transmitter; slave: the stream source / screen side.
interface vga_if;
  import vga_pkg::*;

  logic [RGB_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_valid;
  logic             pix_ready;

  logic             VGA_CLK;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_BLANK;
  logic             VGA_SYNC;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;

  logic             frame_start;
  logic             underflow;
  logic             sync_err;

  modport master (
    input  pix_data, pix_sof, pix_valid,
    output pix_ready,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B,
    output frame_start, underflow, sync_err
  );

  modport slave (
    output pix_data, pix_sof, pix_valid,
    input  pix_ready,
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B,
    input  frame_start, underflow, sync_err
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical counters and the combinational
// timing flags for the current position (registered by the caller).
module vga_timing_gen import vga_pkg::*; #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic pixel_clk,
  input  logic pixel_rst,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic frame_start_pre
);

  localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
  localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // Raster counters: never stall, wrap at line and frame end
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(HTOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(VTOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Line/frame order is active, front porch, pulse, back porch
  assign active          = (hcnt < HW'(HDISP)) && (vcnt < VW'(VDISP));
  assign hs_n            = !((hcnt >= HW'(HDISP + HFP)) &&
                             (hcnt <  HW'(HDISP + HFP + HPULSE)));
  assign vs_n            = !((vcnt >= VW'(VDISP + VFP)) &&
                             (vcnt <  VW'(VDISP + VFP + VPULSE)));
  assign frame_start_pre = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_pixel_tx.sv
// VGA transmitter: locks a valid/ready pixel stream onto the raster using
// start-of-frame markers, blanks to black on underflow or misalignment and
// re-locks at the next frame. All VGA outputs except VGA_CLK are registered.
module vga_pixel_tx import vga_pkg::*; #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic  pixel_clk,
  input  logic  pixel_rst,
  vga_if.master vga
);

  logic      active, hs_n, vs_n, frame_start_pre;
  tx_state_t state, state_nxt;
  rgb_t      pix_rgb, rgb_nxt;
  logic      ready, sof_ok, underflow_nxt, sync_err_nxt;

  rgb_t      rgb_p1;
  logic      hs_n_p1, vs_n_p1, blank_p1, frame_start_p1, underflow_p1, sync_err_p1;

  vga_timing_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .pixel_clk       (pixel_clk),
    .pixel_rst       (pixel_rst),
    .active          (active),
    .hs_n            (hs_n),
    .vs_n            (vs_n),
    .frame_start_pre (frame_start_pre)
  );

  assign pix_rgb = rgb_t'(vga.pix_data);
  // A pixel is aligned when its sof flag matches "this is slot (0,0)".
  assign sof_ok  = (vga.pix_sof == frame_start_pre);

  // Lock state register
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) state <= SEARCH;
    else           state <= state_nxt;
  end

  // Handshake, colour selection and lock/unlock decisions for this slot
  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    rgb_nxt       = '0;
    underflow_nxt = 1'b0;
    sync_err_nxt  = 1'b0;
    case (state)
      SEARCH: begin
        // Drain non-sof pixels; hold a sof pixel until the raster is at (0,0).
        ready = !(vga.pix_valid && vga.pix_sof) || frame_start_pre;
        if (vga.pix_valid && vga.pix_sof && frame_start_pre) begin
          rgb_nxt   = pix_rgb;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ready = active;
        if (active) begin
          if (!vga.pix_valid) begin
            underflow_nxt = 1'b1;
            state_nxt     = SEARCH;
          end else if (!sof_ok) begin
            sync_err_nxt  = 1'b1;
            state_nxt     = SEARCH;
          end else begin
            rgb_nxt       = pix_rgb;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
    // Nothing is consumed while the transmitter is held in reset.
    if (pixel_rst) ready = 1'b0;
  end

  // Output stage p1: timing and colour of position (h,v) appear one cycle later
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hs_n_p1        <= 1'b1;
      vs_n_p1        <= 1'b1;
      blank_p1       <= 1'b0;
      rgb_p1         <= '0;
      frame_start_p1 <= 1'b0;
      underflow_p1   <= 1'b0;
      sync_err_p1    <= 1'b0;
    end else begin
      hs_n_p1        <= hs_n;
      vs_n_p1        <= vs_n;
      blank_p1       <= active;
      rgb_p1         <= active ? rgb_nxt : '0;
      frame_start_p1 <= frame_start_pre;
      underflow_p1   <= underflow_nxt;
      sync_err_p1    <= sync_err_nxt;
    end
  end

  assign vga.pix_ready   = ready;
  assign vga.VGA_CLK     = ~pixel_clk;
  assign vga.VGA_SYNC    = 1'b0;
  assign vga.VGA_HS      = hs_n_p1;
  assign vga.VGA_VS      = vs_n_p1;
  assign vga.VGA_BLANK   = blank_p1;
  assign vga.VGA_R       = rgb_p1.r;
  assign vga.VGA_G       = rgb_p1.g;
  assign vga.VGA_B       = rgb_p1.b;
  assign vga.frame_start = frame_start_p1;
  assign vga.underflow   = underflow_p1;
  assign vga.sync_err    = sync_err_p1;

endmodule
